// File: rtl/sprite_frame_scheduler_if.sv
// Bundle between the frame scheduler and the sprite blocks / VGA adapter.
// The master side is the scheduler; the slave side is the sprites, adapter and status consumers.
interface sprite_frame_scheduler_if #(
   parameter int unsigned NUM_SPRITES = 4
);
   logic [NUM_SPRITES-1:0]   erase_req;
   logic [NUM_SPRITES-1:0]   draw_req;
   logic [NUM_SPRITES-1:0]   finish;
   logic [NUM_SPRITES-1:0]   collision;
   logic [9*NUM_SPRITES-1:0] sprite_x;
   logic [8*NUM_SPRITES-1:0] sprite_y;
   logic [3*NUM_SPRITES-1:0] sprite_colour;
   logic [8:0]               vga_x;
   logic [7:0]               vga_y;
   logic [2:0]               vga_colour;
   logic                     vga_plot;
   logic                     frame_tick;
   logic                     busy;
   logic [NUM_SPRITES-1:0]   hit_mask;
   logic                     timeout_err;
   logic                     frame_overrun;

   modport master (
      output erase_req, draw_req, vga_x, vga_y, vga_colour, vga_plot,
             frame_tick, busy, hit_mask, timeout_err, frame_overrun,
      input  finish, collision, sprite_x, sprite_y, sprite_colour
   );

   modport slave (
      input  erase_req, draw_req, vga_x, vga_y, vga_colour, vga_plot,
             frame_tick, busy, hit_mask, timeout_err, frame_overrun,
      output finish, collision, sprite_x, sprite_y, sprite_colour
   );
endinterface

// File: rtl/sprite_frame_scheduler.sv
// Once per frame, walks every sprite through erase -> draw -> gap, muxes the active sprite onto
// the single VGA plot port and collects collision / error status.
module sprite_frame_scheduler #(
   parameter int unsigned NUM_SPRITES  = 4,
   parameter int unsigned FRAME_DIV    = 833334,
   parameter int unsigned ERASE_CYCLES = 44,
   parameter int unsigned DRAW_TIMEOUT = 255
) (
   input  logic                        clk,
   input  logic                        reset,
   sprite_frame_scheduler_if.master    sched
);

   localparam int unsigned IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int unsigned FCNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int unsigned CNT_W  = 9;

   localparam logic [CNT_W-1:0]  ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  DRAW_LAST  = CNT_W'(DRAW_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  GUARD_CNT  = CNT_W'(2);
   localparam logic [CNT_W-1:0]  PLOT_CNT   = CNT_W'(4);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_SPRITES - 1);
   localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(FRAME_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_GAP} state_e;

   state_e                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
   logic [FCNT_W-1:0]        frame_cnt_q, frame_cnt_d;
   logic                     tick_q;
   logic                     draw_timeout;
   logic [NUM_SPRITES-1:0]   erase_req_q, draw_req_q, hit_q;
   logic [8:0]               vga_x_q, sel_x;
   logic [7:0]               vga_y_q, sel_y;
   logic [2:0]               vga_colour_q, sel_colour;
   logic                     vga_plot_q, sel_fin;
   logic                     busy_q, timeout_q, overrun_q;

   // Active-sprite select from the packed input buses
   always_comb begin
      sel_x      = '0;
      sel_y      = '0;
      sel_colour = '0;
      sel_fin    = 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_x      = sched.sprite_x[9*i +: 9];
            sel_y      = sched.sprite_y[8*i +: 8];
            sel_colour = sched.sprite_colour[3*i +: 3];
            sel_fin    = sched.finish[i];
         end
      end
   end

   assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
   assign frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + FCNT_W'(1);

   // Walk sequencing; finish is ignored for the first two DRAW cycles (stale level from last frame)
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_inc;
      draw_timeout = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (tick_q) begin
               state_d = S_ERASE;
               idx_d   = '0;
            end
         end
         S_ERASE: begin
            if (cnt_q == ERASE_LAST) begin
               state_d = S_DRAW;
               cnt_d   = '0;
            end
         end
         S_DRAW: begin
            if ((cnt_q >= GUARD_CNT) && sel_fin) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end else if (cnt_q == DRAW_LAST) begin
               state_d      = S_GAP;
               cnt_d        = '0;
               draw_timeout = 1'b1;
            end
         end
         S_GAP: begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_ERASE;
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Request lines are derived from the next state so they line up with the state they belong to
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         frame_cnt_q  <= '0;
         tick_q       <= 1'b0;
         erase_req_q  <= '0;
         draw_req_q   <= '0;
         busy_q       <= 1'b0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
         hit_q        <= '0;
         timeout_q    <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         frame_cnt_q  <= frame_cnt_d;
         tick_q       <= (frame_cnt_d == FRAME_LAST);
         erase_req_q  <= ((state_d == S_ERASE) && (state_q != S_ERASE))
                         ? (NUM_SPRITES'(1) << idx_d) : '0;
         draw_req_q   <= (state_d == S_DRAW) ? (NUM_SPRITES'(1) << idx_d) : '0;
         busy_q       <= (state_d != S_IDLE);
         vga_x_q      <= sel_x;
         vga_y_q      <= sel_y;
         vga_colour_q <= sel_colour;
         vga_plot_q   <= ((state_q == S_ERASE) || (state_q == S_DRAW))
                         && (cnt_q >= PLOT_CNT) && !sel_fin;
         hit_q        <= tick_q ? sched.collision : (hit_q | sched.collision);
         timeout_q    <= timeout_q | draw_timeout;
         overrun_q    <= overrun_q | (tick_q && (state_q != S_IDLE));
      end
   end

   assign sched.erase_req     = erase_req_q;
   assign sched.draw_req      = draw_req_q;
   assign sched.vga_x         = vga_x_q;
   assign sched.vga_y         = vga_y_q;
   assign sched.vga_colour    = vga_colour_q;
   assign sched.vga_plot      = vga_plot_q;
   assign sched.frame_tick    = tick_q;
   assign sched.busy          = busy_q;
   assign sched.hit_mask      = hit_q;
   assign sched.timeout_err   = timeout_q;
   assign sched.frame_overrun = overrun_q;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Directed bench for sprite_frame_scheduler: per-frame walk vectors plus reset, collision and
// frame-overrun sequences.
module tb_sprite_frame_scheduler;

   localparam int unsigned NS    = 2;
   localparam int unsigned FD    = 400;
   localparam int unsigned FD_OV = 100;
   localparam int          NEVER = 9999;

   logic clk = 1'b0;
   logic reset;
   logic rst_ov;
   always #5 clk = ~clk;

   sprite_frame_scheduler_if #(.NUM_SPRITES(NS)) bus ();
   sprite_frame_scheduler_if #(.NUM_SPRITES(NS)) bus_ov ();

   sprite_frame_scheduler #(.NUM_SPRITES(NS), .FRAME_DIV(FD), .ERASE_CYCLES(44), .DRAW_TIMEOUT(255))
      dut (.clk(clk), .reset(reset), .sched(bus.master));

   sprite_frame_scheduler #(.NUM_SPRITES(NS), .FRAME_DIV(FD_OV), .ERASE_CYCLES(44), .DRAW_TIMEOUT(255))
      dut_ov (.clk(clk), .reset(rst_ov), .sched(bus_ov.master));

   int checks = 0;
   int errors = 0;

   logic [8:0] xs [NS];
   logic [7:0] ys [NS];
   logic [2:0] cs [NS];

   typedef struct {
      int d0;
      int d1;
      int exp_draw0;
      int exp_draw1;
      int exp_busy;
      int exp_to;
   } walk_vec_t;

   walk_vec_t vec [5];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_tick(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (bus.frame_tick) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s: no frame_tick within 1000 cycles", tag);
      end
   endtask

   // finish[i] rises once draw_req[i] has been seen high for d[i] cycles (d=0: high from the start)
   task automatic run_walk(input walk_vec_t v, input int row);
      int d [NS];
      int dcnt [NS];
      int en [NS];
      int e_first [NS];
      int dr_first [NS];
      int dr_last [NS];
      int busy_n = 0, onehot_err = 0, vga_err = 0;
      int prev_draw = -1, prev_dcnt = 0, cur;
      logic [NS-1:0] prev_fin;
      bit started = 1'b0, done = 1'b0;
      wait_tick($sformatf("row%0d tick", row));
      d[0] = v.d0;
      d[1] = v.d1;
      for (int i = 0; i < NS; i++) begin
         dcnt[i] = 0; en[i] = 0; e_first[i] = -1; dr_first[i] = -1; dr_last[i] = -1;
      end
      bus.finish = {(d[1] == 0), (d[0] == 0)};
      prev_fin   = bus.finish;
      for (int c = 1; c <= 1000; c++) begin
         @(negedge clk);
         if (prev_draw >= 0) begin
            if (bus.vga_x !== xs[prev_draw] || bus.vga_y !== ys[prev_draw] ||
                bus.vga_colour !== cs[prev_draw] ||
                bus.vga_plot !== ((prev_dcnt >= 5) && !prev_fin[prev_draw]))
               vga_err++;
         end
         cur = -1;
         for (int i = 0; i < NS; i++) begin
            if (bus.draw_req[i]) begin
               dcnt[i]++;
               cur = i;
               if (dr_first[i] < 0) dr_first[i] = c;
               dr_last[i] = c;
            end
            if (bus.erase_req[i]) begin
               en[i]++;
               if (e_first[i] < 0) e_first[i] = c;
            end
         end
         if ($countones({bus.erase_req, bus.draw_req}) > 1) onehot_err++;
         if (bus.busy) begin
            busy_n++;
            started = 1'b1;
         end
         for (int i = 0; i < NS; i++) bus.finish[i] = (dcnt[i] >= d[i]);
         prev_draw = cur;
         prev_dcnt = (cur >= 0) ? dcnt[cur] : 0;
         prev_fin  = bus.finish;
         if (started && !bus.busy) begin
            done = 1'b1;
            break;
         end
      end
      chk($sformatf("row%0d walk_done", row), int'(done), 1);
      chk($sformatf("row%0d draw0_cycles", row), dcnt[0], v.exp_draw0);
      chk($sformatf("row%0d draw1_cycles", row), dcnt[1], v.exp_draw1);
      chk($sformatf("row%0d erase0_pulses", row), en[0], 1);
      chk($sformatf("row%0d erase1_pulses", row), en[1], 1);
      chk($sformatf("row%0d busy_cycles", row), busy_n, v.exp_busy);
      chk($sformatf("row%0d erase_to_draw", row), dr_first[0] - e_first[0], 44);
      chk($sformatf("row%0d gap_to_next_erase", row), e_first[1] - dr_last[0], 2);
      chk($sformatf("row%0d timeout_err", row), int'(bus.timeout_err), v.exp_to);
      chk($sformatf("row%0d vga_mux_errs", row), vga_err, 0);
      chk($sformatf("row%0d onehot_errs", row), onehot_err, 0);
   endtask

   initial begin
      int n;
      bit seen;
      int busy_n, e0, e1, dr1;

      xs[0] = 9'd100; xs[1] = 9'd301;
      ys[0] = 8'd20;  ys[1] = 8'd200;
      cs[0] = 3'd5;   cs[1] = 3'd2;

      vec[0] = '{d0: 50,  d1: 50,    exp_draw0: 50,  exp_draw1: 50,  exp_busy: 190, exp_to: 0};
      vec[1] = '{d0: 0,   d1: 10,    exp_draw0: 3,   exp_draw1: 10,  exp_busy: 103, exp_to: 0};
      vec[2] = '{d0: 3,   d1: 2,     exp_draw0: 3,   exp_draw1: 3,   exp_busy: 96,  exp_to: 0};
      vec[3] = '{d0: 50,  d1: NEVER, exp_draw0: 50,  exp_draw1: 255, exp_busy: 395, exp_to: 1};
      vec[4] = '{d0: 100, d1: 4,     exp_draw0: 100, exp_draw1: 4,   exp_busy: 194, exp_to: 1};

      reset  = 1'b1;
      rst_ov = 1'b1;
      bus.finish        = 2'b11;
      bus.collision     = 2'b00;
      bus.sprite_x      = {xs[1], xs[0]};
      bus.sprite_y      = {ys[1], ys[0]};
      bus.sprite_colour = {cs[1], cs[0]};
      bus_ov.finish        = 2'b00;
      bus_ov.collision     = 2'b00;
      bus_ov.sprite_x      = {xs[1], xs[0]};
      bus_ov.sprite_y      = {ys[1], ys[0]};
      bus_ov.sprite_colour = {cs[1], cs[0]};

      repeat (3) @(negedge clk);
      chk("rst erase_req", int'(bus.erase_req), 0);
      chk("rst draw_req", int'(bus.draw_req), 0);
      chk("rst busy", int'(bus.busy), 0);
      chk("rst vga_plot", int'(bus.vga_plot), 0);
      chk("rst frame_tick", int'(bus.frame_tick), 0);
      chk("rst hit_mask", int'(bus.hit_mask), 0);
      chk("rst timeout_err", int'(bus.timeout_err), 0);
      chk("rst frame_overrun", int'(bus.frame_overrun), 0);

      // Frame counter: first tick at count FRAME_DIV-1, then every FRAME_DIV cycles
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         n++;
         if (bus.frame_tick) break;
      end
      chk("first_tick_delay", n, int'(FD) - 1);
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         n++;
         if (bus.frame_tick) break;
      end
      chk("tick_period", n, int'(FD));

      for (int r = 0; r < 5; r++) run_walk(vec[r], r);

      // Collision pulse is sticky until the next frame tick reloads from collision
      bus.finish = 2'b11;
      @(negedge clk);
      bus.collision = 2'b10;
      @(negedge clk);
      bus.collision = 2'b00;
      chk("hit_mask after pulse", int'(bus.hit_mask), 2);
      repeat (5) @(negedge clk);
      chk("hit_mask sticky", int'(bus.hit_mask), 2);
      wait_tick("hit tick");
      chk("hit_mask at tick", int'(bus.hit_mask), 2);
      @(negedge clk);
      chk("hit_mask after tick", int'(bus.hit_mask), 0);
      chk("no overrun main", int'(bus.frame_overrun), 0);

      // Reset while a sprite is mid-draw
      wait_tick("reset tick");
      bus.finish = 2'b00;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.draw_req != '0) begin
            seen = 1'b1;
            break;
         end
      end
      chk("reached draw before reset", int'(seen), 1);
      repeat (5) @(negedge clk);
      chk("pre-reset draw_req", int'(bus.draw_req), 1);
      chk("pre-reset timeout_err", int'(bus.timeout_err), 1);
      reset = 1'b1;
      @(negedge clk);
      chk("midreset draw_req", int'(bus.draw_req), 0);
      chk("midreset erase_req", int'(bus.erase_req), 0);
      chk("midreset vga_plot", int'(bus.vga_plot), 0);
      chk("midreset busy", int'(bus.busy), 0);
      chk("midreset timeout_err", int'(bus.timeout_err), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("post-reset draw_req", int'(bus.draw_req), 0);
      chk("post-reset busy", int'(bus.busy), 0);

      // Overrun: walk of 600 cycles against a 100-cycle frame
      rst_ov = 1'b0;
      @(negedge clk);
      chk("ov initial overrun", int'(bus_ov.frame_overrun), 0);
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (bus_ov.busy) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("ov walk start", int'(seen), 1);
      chk("ov overrun at start", int'(bus_ov.frame_overrun), 0);
      busy_n = 0; e0 = 0; e1 = 0; dr1 = 0;
      for (int i = 0; i < 2000; i++) begin
         if (!bus_ov.busy) break;
         busy_n++;
         e0  += int'(bus_ov.erase_req[0]);
         e1  += int'(bus_ov.erase_req[1]);
         dr1 += int'(bus_ov.draw_req[1]);
         @(negedge clk);
      end
      chk("ov busy_cycles", busy_n, 600);
      chk("ov erase0_pulses", e0, 1);
      chk("ov erase1_pulses", e1, 1);
      chk("ov draw1_cycles", dr1, 255);
      chk("ov frame_overrun", int'(bus_ov.frame_overrun), 1);
      chk("ov timeout_err", int'(bus_ov.timeout_err), 1);
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus_ov.busy) begin
            seen = 1'b1;
            break;
         end
      end
      chk("ov next walk on next tick", int'(seen), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
